lut_interp_pipe: RTL and testbench

Parametrised, pipelined successor to the fixed 8-bit-index constant table used by the transcendental-function datapaths. Holds a runtime-loadable table of 2^IDX_W+1 unsigned entries and returns either the raw entry or a linearly interpolated value between adjacent entries, under a valid/ready handshake. It sits between the argument-reduction stage and the iteration/polynomial stage. A tag travels with each lookup so several channels can share one instance.

---
 rtl/lut_interp_pipe.sv | 135 +++++++++++++
 tb/tb_lut_interp_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_interp_pipe.sv
// Runtime-loadable lookup table with optional linear interpolation between
// adjacent entries; three-stage pipeline under a single global stall enable.
`timescale 1ns/1ps
module lut_interp_pipe #(
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned VAL_W  = 24,
    parameter int unsigned TAG_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_W+FRAC_W-1:0] in_x,
    input  logic                    in_mode,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VAL_W-1:0]        out_y,
    output logic [TAG_W-1:0]        out_tag,
    input  logic                    wr_en,
    input  logic [IDX_W:0]          wr_addr,
    input  logic [VAL_W-1:0]        wr_data
);
    localparam int unsigned X_W   = IDX_W + FRAC_W;
    localparam int unsigned A_W   = IDX_W + 1;
    localparam int unsigned DEPTH = (1 << IDX_W) + 1;
    localparam int unsigned D_W   = VAL_W + 1;
    localparam int unsigned P_W   = VAL_W + FRAC_W + 2;
    localparam logic signed [P_W-1:0] RND = P_W'(1 << (FRAC_W - 1));

    logic [VAL_W-1:0] tbl [DEPTH];

    logic             en;
    logic             acc;
    logic [A_W-1:0]   a0;
    logic [A_W-1:0]   a1;

    // stage 1
    logic             v1;
    logic [VAL_W-1:0] t0_1;
    logic [VAL_W-1:0] t1_1;
    logic [FRAC_W-1:0] f1;
    logic             m1;
    logic [TAG_W-1:0] tag1;

    // stage 2
    logic             v2;
    logic [VAL_W-1:0] t0_2;
    logic signed [P_W-1:0] p2;
    logic [TAG_W-1:0] tag2;

    logic signed [D_W-1:0] d_c;
    logic signed [P_W-1:0] prod_c;
    logic signed [P_W-1:0] rnd_c;
    logic signed [P_W-1:0] sum_c;
    logic                  unused_bits;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign acc      = in_valid && en;
    assign a0       = {1'b0, in_x[X_W-1:FRAC_W]};
    assign a1       = a0 + A_W'(1);

    // Table storage; out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(DEPTH); k++) tbl[k] <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (wr_en && (wr_addr == A_W'(k))) tbl[k] <= wr_data;
            end
        end
    end

    // Difference and product; direct mode forces a zero correction term.
    always_comb begin
        d_c    = $signed({1'b0, t1_1}) - $signed({1'b0, t0_1});
        prod_c = P_W'(d_c) * P_W'($signed({1'b0, f1}));
        rnd_c  = (p2 + RND) >>> FRAC_W;
        sum_c  = $signed({{(P_W - VAL_W){1'b0}}, t0_2}) + rnd_c;
    end

    assign unused_bits = ^sum_c[P_W-1:VAL_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            t0_1 <= '0;
            t1_1 <= '0;
            f1   <= '0;
            m1   <= 1'b0;
            tag1 <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (acc) begin
                t0_1 <= tbl[a0];
                t1_1 <= tbl[a1];
                f1   <= in_x[FRAC_W-1:0];
                m1   <= in_mode;
                tag1 <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            t0_2 <= '0;
            p2   <= '0;
            tag2 <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                t0_2 <= t0_1;
                p2   <= m1 ? prod_c : '0;
                tag2 <= tag1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= v2;
            if (v2) begin
                out_y   <= sum_c[VAL_W-1:0];
                out_tag <= tag2;
            end
        end
    end
endmodule

// File: tb/tb_lut_interp_pipe.sv
// Directed bench for lut_interp_pipe: reset, interpolation, boundaries,
// streaming with tags, backpressure and read/write collision.
`timescale 1ns/1ps
module tb_lut_interp_pipe;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic        in_mode;
    logic [1:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_y;
    logic [1:0]  out_tag;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [23:0] wr_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [23:0] mdl [257];
    logic [25:0] got_q [$];
    int          got_cyc [$];
    logic [25:0] exp_q [$];

    lut_interp_pipe #(.IDX_W(8), .FRAC_W(8), .VAL_W(24), .TAG_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_tag(out_tag),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collect every completed output handshake with its cycle stamp.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back({out_tag, out_y});
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 257; k++) mdl[k] = '0;
    endtask

    task automatic wr(input logic [8:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (a <= 9'd256) mdl[a] = d;
        step();
        wr_en = 1'b0;
    endtask

    function automatic logic [23:0] expect_y(input logic [15:0] x, input logic mode);
        int     i;
        longint f;
        longint d;
        longint r;
        i = int'(x[15:8]);
        f = longint'(x[7:0]);
        if (!mode) return mdl[i];
        d = longint'(mdl[i+1]) - longint'(mdl[i]);
        r = (d * f + 128) >>> 8;
        return 24'(longint'(mdl[i]) + r);
    endfunction

    // Single isolated lookup with latency check (pipeline must be empty).
    task automatic lookup(input string name, input logic [15:0] x, input logic mode,
                          input logic [1:0] tag, input logic [23:0] exp);
        in_valid = 1'b1;
        in_x     = x;
        in_mode  = mode;
        in_tag   = tag;
        #1;
        chk({name, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({name, "_lat1"}, 32'(out_valid), 32'd0);
        step();
        chk({name, "_lat2"}, 32'(out_valid), 32'd0);
        step();
        chk({name, "_vld"}, 32'(out_valid), 32'd1);
        chk({name, "_y"}, 32'(out_y), 32'(exp));
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        step();
    endtask

    initial begin
        logic [15:0] x;
        logic        m;
        logic [1:0]  t;
        logic [23:0] held_y;
        logic [1:0]  held_tag;
        logic        stall;
        logic        accd;
        int          k;
        int          g;

        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_mode = 1'b0; in_tag = '0;
        out_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        clear_model();
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        step();

        // Asynchronous reset with three lookups in flight.
        wr(9'd5, 24'd1000);
        wr(9'd6, 24'd2000);
        got_q.delete(); got_cyc.delete();
        for (int r = 0; r < 3; r++) begin
            in_valid = 1'b1; in_x = 16'h0580; in_mode = 1'b1; in_tag = 2'(r + 1);
            step();
        end
        in_valid = 1'b0;
        chk("midrst_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_y", 32'(out_y), 32'd0);
        chk("midrst_out_tag", 32'(out_tag), 32'd0);
        step();
        rst_n = 1'b1;
        clear_model();
        #1;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        repeat (6) step();
        chk("postrst_no_stale", 32'(got_q.size()), 32'd0);
        lookup("tbl_cleared", 16'h0500, 1'b0, 2'd0, 24'd0);

        // Interpolation rising and falling, direct mode ignores fraction.
        wr(9'd5, 24'd1000);
        wr(9'd6, 24'd2000);
        lookup("interp_rise", 16'h0580, 1'b1, 2'd1, 24'd1500);
        wr(9'd5, 24'd2000);
        wr(9'd6, 24'd1000);
        lookup("interp_fall", 16'h0580, 1'b1, 2'd2, 24'd1500);
        lookup("direct_frac", 16'h05FF, 1'b0, 2'd3, 24'd2000);

        // Top boundary: i = 255 reads entry 256, no wrap to entry 0.
        wr(9'd255, 24'h200000);
        wr(9'd256, 24'h100000);
        lookup("top_direct", 16'hFFFF, 1'b0, 2'd0, 24'h200000);
        lookup("top_interp", 16'hFFFF, 1'b1, 2'd1, 24'h101000);
        lookup("top_f0", 16'hFF00, 1'b1, 2'd2, 24'h200000);

        // Out-of-range write must not alias onto entry 44.
        wr(9'd300, 24'h000777);
        lookup("oob_write", 16'h2C00, 1'b0, 2'd3, 24'd0);

        // Same-cycle write sees old value; next lookup sees the new one.
        wr(9'd7, 24'd11);
        got_q.delete(); got_cyc.delete();
        wr_en = 1'b1; wr_addr = 9'd7; wr_data = 24'd42;
        in_valid = 1'b1; in_x = 16'h0700; in_mode = 1'b0; in_tag = 2'd2;
        step();
        wr_en = 1'b0;
        mdl[7] = 24'd42;
        in_tag = 2'd3;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("coll_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("coll_old", 32'(got_q[0]), 32'({2'd2, 24'd11}));
            chk("coll_new", 32'(got_q[1]), 32'({2'd3, 24'd42}));
        end

        // Back-to-back stream, mixed modes and tags.
        for (int r = 0; r <= 16; r++) wr(9'(r), 24'((r * 37) % 11 * 50000 + r));
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        for (int r = 0; r < 16; r++) begin
            x = {8'(r), 8'(r * 53 + 9)};
            m = (r % 3) != 0;
            t = 2'(r % 4);
            in_valid = 1'b1; in_x = x; in_mode = m; in_tag = t;
            #1;
            chk("tp_in_ready", 32'(in_ready), 32'd1);
            exp_q.push_back({t, expect_y(x, m)});
            step();
        end
        in_valid = 1'b0;
        g = 0;
        while (got_q.size() < 16 && g < 20) begin step(); g++; end
        chk("tp_count", 32'(got_q.size()), 32'd16);
        if (got_q.size() == 16) begin
            for (int r = 0; r < 16; r++) chk("tp_result", 32'(got_q[r]), 32'(exp_q[r]));
            chk("tp_consecutive", 32'(got_cyc[15] - got_cyc[0]), 32'd15);
        end

        // Backpressure: out_ready low for five cycles while streaming.
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        k = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 5 && c < 10);
            x = {8'(k + 1), 8'(k * 29 + 7)};
            m = k[0];
            t = 2'(k % 4);
            in_valid = (k < 12); in_x = x; in_mode = m; in_tag = t;
            #1;
            stall = !out_ready && out_valid;
            held_y = out_y;
            held_tag = out_tag;
            if (stall) chk("bp_in_ready", 32'(in_ready), 32'd0);
            accd = in_valid && in_ready;
            if (accd) exp_q.push_back({t, expect_y(x, m)});
            step();
            if (stall) begin
                chk("bp_hold_y", 32'(out_y), 32'(held_y));
                chk("bp_hold_tag", 32'(out_tag), 32'(held_tag));
            end
            if (accd) k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while (got_q.size() < 12 && g < 20) begin step(); g++; end
        chk("bp_count", 32'(got_q.size()), 32'd12);
        if (got_q.size() == 12 && exp_q.size() == 12) begin
            for (int r = 0; r < 12; r++) chk("bp_result", 32'(got_q[r]), 32'(exp_q[r]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
